// File: rtl/bus_arb_pkg.sv
// Shared definitions for the internal BUS arbiter: FSM state encoding and ID-width helper.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn  = 2'd1,
        StTurn = 2'd2
    } arb_state_e;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, with wrap.
module rr_picker
    import bus_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 8,
    localparam int unsigned IdW = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IdW-1:0]   pointer,
    output logic             found,
    output logic [N_REQ-1:0] pick,
    output logic [IdW-1:0]   index
);

    logic           hi_hit;
    logic [IdW-1:0] hi_idx;
    logic           lo_hit;
    logic [IdW-1:0] lo_idx;

    // Downward scan so the last hit written is the lowest index; the "hi" set only
    // considers bits at or above the pointer, the "lo" set is the wrapped fallback.
    always_comb begin
        hi_hit = 1'b0;
        hi_idx = '0;
        lo_hit = 1'b0;
        lo_idx = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_hit = 1'b1;
                lo_idx = IdW'(i);
                if (i >= int'(pointer)) begin
                    hi_hit = 1'b1;
                    hi_idx = IdW'(i);
                end
            end
        end
    end

    always_comb begin
        found = lo_hit;
        index = hi_hit ? hi_idx : lo_idx;
        pick  = '0;
        if (found) begin
            pick[index] = 1'b1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for the shared internal BUS, with turnaround idle cycles
// between owners and a hold watchdog that forces release of a stuck owner.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned N_REQ       = 8,
    parameter int unsigned TURN_CYCLES = 1,
    parameter int unsigned MAX_HOLD    = 16,
    localparam int unsigned IdW = id_width(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IdW-1:0]   grant_id,
    output logic             bus_busy,
    output logic             timeout,
    output logic [IdW-1:0]   timeout_id
);

    localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
    localparam int unsigned TurnW = $clog2(TURN_CYCLES + 1);

    localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);
    localparam logic [TurnW-1:0] TurnMax = TurnW'(TURN_CYCLES);
    localparam logic [IdW-1:0]   LastId  = IdW'(N_REQ - 1);

    arb_state_e       state_q, state_d;
    logic [IdW-1:0]   ptr_q, ptr_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [TurnW-1:0] turn_q, turn_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IdW-1:0]   grant_id_q, grant_id_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic [IdW-1:0]   timeout_id_q, timeout_id_d;

    logic             pick_found;
    logic [N_REQ-1:0] pick_onehot;
    logic [IdW-1:0]   pick_id;
    logic             owner_req;
    logic             arbitrate;
    logic             release_bus;
    logic [IdW-1:0]   next_ptr;

    rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req     (req),
        .pointer (ptr_q),
        .found   (pick_found),
        .pick    (pick_onehot),
        .index   (pick_id)
    );

    // Owner still holds its request; masking with the one-hot grant avoids indexing by id.
    assign owner_req = |(req & grant_q);
    assign next_ptr  = (grant_id_q == LastId) ? '0 : grant_id_q + IdW'(1);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        hold_d       = hold_q;
        turn_d       = turn_q;
        grant_d      = grant_q;
        grant_id_d   = grant_id_q;
        timeout_d    = 1'b0;
        timeout_id_d = timeout_id_q;
        arbitrate    = 1'b0;
        release_bus  = 1'b0;

        unique case (state_q)
            StIdle: begin
                arbitrate = 1'b1;
            end
            StOwn: begin
                if (!owner_req) begin
                    // A drop coinciding with the hold limit is a normal release.
                    release_bus = 1'b1;
                end else if (hold_q == HoldMax) begin
                    release_bus  = 1'b1;
                    timeout_d    = 1'b1;
                    timeout_id_d = grant_id_q;
                end else if (hold_q != HoldMax) begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            StTurn: begin
                if (turn_q == TurnMax) begin
                    arbitrate = 1'b1;
                end else begin
                    turn_d = turn_q + TurnW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (release_bus) begin
            grant_d    = '0;
            grant_id_d = '0;
            ptr_d      = next_ptr;
            hold_d     = '0;
            turn_d     = TurnW'(1);
            state_d    = StTurn;
        end

        if (arbitrate) begin
            if (pick_found) begin
                grant_d    = pick_onehot;
                grant_id_d = pick_id;
                hold_d     = HoldW'(1);
                state_d    = StOwn;
            end else begin
                grant_d    = '0;
                grant_id_d = '0;
                state_d    = StIdle;
            end
        end

        busy_d = |grant_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            hold_q       <= '0;
            turn_q       <= '0;
            grant_q      <= '0;
            grant_id_q   <= '0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            timeout_id_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            hold_q       <= hold_d;
            turn_q       <= turn_d;
            grant_q      <= grant_d;
            grant_id_q   <= grant_id_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
            timeout_id_q <= timeout_id_d;
        end
    end

    assign grant      = grant_q;
    assign grant_id   = grant_id_q;
    assign bus_busy   = busy_q;
    assign timeout    = timeout_q;
    assign timeout_id = timeout_id_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_bus_arbiter;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       bus_busy;
    logic       timeout;
    logic [2:0] timeout_id;

    int checks   = 0;
    int failures = 0;

    bus_arbiter #(
        .N_REQ       (8),
        .TURN_CYCLES (1),
        .MAX_HOLD    (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .grant      (grant),
        .grant_id   (grant_id),
        .bus_busy   (bus_busy),
        .timeout    (timeout),
        .timeout_id (timeout_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic [7:0] grant;
        logic [2:0] id;
        logic       to;
        logic [2:0] tid;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Drive req for one cycle, then sample all outputs just after the rising edge.
    task automatic step(input logic [7:0] r, input logic [7:0] eg, input logic [2:0] eid,
                        input logic eto, input logic [2:0] etid, input string nm);
        req = r;
        @(posedge clk);
        #1;
        check({nm, ".grant"}, 32'(grant), 32'(eg));
        check({nm, ".grant_id"}, 32'(grant_id), 32'(eid));
        check({nm, ".bus_busy"}, 32'(bus_busy), 32'(|eg));
        check({nm, ".timeout"}, 32'(timeout), 32'(eto));
        check({nm, ".timeout_id"}, 32'(timeout_id), 32'(etid));
    endtask

    // Grant must be one-hot or zero and bus_busy must mirror it on every cycle.
    always @(negedge clk) begin
        if (reset) begin
            check("inv.onehot", 32'($countones(grant) <= 1), 32'(1));
            check("inv.busy", 32'(bus_busy), 32'(|grant));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b0;
        req   = '0;

        // Reset-driven pointer 0 sequence: single request, released owner, unlatched pulse,
        // then simultaneous requests 0 and 7.
        vecs[0]  = '{8'h04, 8'h04, 3'd2, 1'b0, 3'd0};
        vecs[1]  = '{8'h00, 8'h00, 3'd0, 1'b0, 3'd0};
        vecs[2]  = '{8'h00, 8'h00, 3'd0, 1'b0, 3'd0};
        vecs[3]  = '{8'h80, 8'h80, 3'd7, 1'b0, 3'd0};
        vecs[4]  = '{8'hA0, 8'h80, 3'd7, 1'b0, 3'd0};
        vecs[5]  = '{8'h80, 8'h80, 3'd7, 1'b0, 3'd0};
        vecs[6]  = '{8'h00, 8'h00, 3'd0, 1'b0, 3'd0};
        vecs[7]  = '{8'h00, 8'h00, 3'd0, 1'b0, 3'd0};
        vecs[8]  = '{8'h81, 8'h01, 3'd0, 1'b0, 3'd0};
        vecs[9]  = '{8'h80, 8'h00, 3'd0, 1'b0, 3'd0};
        vecs[10] = '{8'h80, 8'h80, 3'd7, 1'b0, 3'd0};
        vecs[11] = '{8'h00, 8'h00, 3'd0, 1'b0, 3'd0};
        vecs[12] = '{8'h00, 8'h00, 3'd0, 1'b0, 3'd0};

        #2;
        check("rst.grant", 32'(grant), 32'h0);
        check("rst.grant_id", 32'(grant_id), 32'h0);
        check("rst.bus_busy", 32'(bus_busy), 32'h0);
        check("rst.timeout", 32'(timeout), 32'h0);
        check("rst.timeout_id", 32'(timeout_id), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].req, vecs[i].grant, vecs[i].id, vecs[i].to, vecs[i].tid,
                 $sformatf("vec%0d", i));
        end

        // All requesting; each owner holds one extra cycle, drops, re-raises.
        step(8'hFF, 8'h01, 3'd0, 1'b0, 3'd0, "rr.first");
        for (int o = 0; o < 8; o++) begin
            logic [7:0] cur;
            logic [7:0] nxt;
            cur = 8'h01 << o;
            nxt = 8'h01 << ((o + 1) % 8);
            step(8'hFF, cur, 3'(o), 1'b0, 3'd0, $sformatf("rr.hold%0d", o));
            step(8'hFF & ~cur, 8'h00, 3'd0, 1'b0, 3'd0, $sformatf("rr.gap%0d", o));
            step(8'hFF, nxt, 3'((o + 1) % 8), 1'b0, 3'd0, $sformatf("rr.next%0d", o));
        end
        step(8'h00, 8'h00, 3'd0, 1'b0, 3'd0, "rr.rel");
        step(8'h00, 8'h00, 3'd0, 1'b0, 3'd0, "rr.idle");

        // Sole requester 3 hits the hold limit and wins again after the turnaround.
        for (int c = 0; c < 16; c++) begin
            step(8'h08, 8'h08, 3'd3, 1'b0, 3'd0, $sformatf("wd.hold%0d", c));
        end
        step(8'h08, 8'h00, 3'd0, 1'b1, 3'd3, "wd.force");
        step(8'h08, 8'h08, 3'd3, 1'b0, 3'd3, "wd.regrant");
        step(8'h00, 8'h00, 3'd0, 1'b0, 3'd3, "wd.rel");
        step(8'h00, 8'h00, 3'd0, 1'b0, 3'd3, "wd.idle");

        // Requesters 2 and 3: forced release of 2 hands over to 3; 3 then drops exactly
        // at the hold limit, which must not count as a timeout.
        for (int c = 0; c < 16; c++) begin
            step(8'h0C, 8'h04, 3'd2, 1'b0, 3'd3, $sformatf("wd2.hold%0d", c));
        end
        step(8'h0C, 8'h00, 3'd0, 1'b1, 3'd2, "wd2.force");
        step(8'h0C, 8'h08, 3'd3, 1'b0, 3'd2, "wd2.next");
        for (int c = 0; c < 15; c++) begin
            step(8'h0C, 8'h08, 3'd3, 1'b0, 3'd2, $sformatf("wd2.hold3_%0d", c));
        end
        step(8'h04, 8'h00, 3'd0, 1'b0, 3'd2, "wd2.droplimit");
        step(8'h00, 8'h00, 3'd0, 1'b0, 3'd2, "wd2.idle");

        // Asynchronous reset in the middle of an ownership.
        step(8'h10, 8'h10, 3'd4, 1'b0, 3'd2, "ar.own");
        #2;
        reset = 1'b0;
        #1;
        check("ar.grant", 32'(grant), 32'h0);
        check("ar.bus_busy", 32'(bus_busy), 32'h0);
        check("ar.grant_id", 32'(grant_id), 32'h0);
        check("ar.timeout_id", 32'(timeout_id), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(8'h11, 8'h01, 3'd0, 1'b0, 3'd0, "ar.after");
        step(8'h00, 8'h00, 3'd0, 1'b0, 3'd0, "ar.rel");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
